wddl_and_stage: RTL

- Parametrised WDDL (wave dynamic differential logic) AND stage for the dual-rail AES datapath.
- Takes NUM_IN dual-rail operands of WIDTH bits and computes their bitwise AND:
  - true rail y_t = AND of all a_t;
  - false rail y_f = OR of all a_f.
- Enforces the precharge/evaluate wave with an internal phase FSM and a valid/ready handshake on both sides.
- Both output rails are driven to the precharge value 0 whenever no result is presented.

---
 rtl/wddl_and_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/wddl_and_stage.sv
// wddl_and_stage: WDDL dual-rail AND stage with a precharge/evaluate phase FSM.
//   Result rails: y_t = AND over operands of the true rails, y_f = OR over operands of the false rails.
//   Latency: an operand accepted at edge k yields out_valid=1 after edge k+PRE_CYCLES.
//   Backpressure: in_ready is high only in IDLE; the result is held in EVAL until out_ready.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_t/in_f operand side;
//   out_valid/out_ready/y_t/y_f result side; phase_eval marks EVAL; err is a sticky encoding error.
// Optional macro WDDL_AND_ERRCHK_EN: flags t==f operand bits at capture (sticky err)
//   and forces the affected result bits to 0/0. Without it, err is tied to 0.
module wddl_and_stage #(
  parameter int WIDTH      = 8,
  parameter int NUM_IN     = 2,
  parameter int PRE_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_t,
  input  logic [NUM_IN*WIDTH-1:0] in_f,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        y_t,
  output logic [WIDTH-1:0]        y_f,
  output logic                    phase_eval,
  output logic                    err
);

  localparam int CW = (PRE_CYCLES > 1) ? $clog2(PRE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(PRE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    EVAL = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic [NUM_IN*WIDTH-1:0] op_t, op_f;
  logic [WIDTH-1:0]        and_t, or_f, bad_bits;
  logic [WIDTH-1:0]        y_t_r, y_f_r;
  logic                    accept;

  assign accept = (state == IDLE) && in_valid;

  // Phase FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Phase FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = PRE;
      PRE:     if (cnt == '0)    state_nxt = EVAL;
      EVAL:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Reduction over the captured operands only, so outputs never see in_t/in_f directly.
  always_comb begin
    and_t = '1;
    or_f  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      and_t &= op_t[i*WIDTH +: WIDTH];
      or_f  |= op_f[i*WIDTH +: WIDTH];
    end
  end

`ifdef WDDL_AND_ERRCHK_EN
  logic [WIDTH-1:0] in_bad;
  logic             err_r;

  // A bit position is bad if any operand has t==f there (00 spacer or 11 illegal).
  always_comb begin
    in_bad   = '0;
    bad_bits = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_bad   |= ~(in_t[i*WIDTH +: WIDTH] ^ in_f[i*WIDTH +: WIDTH]);
      bad_bits |= ~(op_t[i*WIDTH +: WIDTH] ^ op_f[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                     err_r <= 1'b0;
    else if (accept && |in_bad)  err_r <= 1'b1;
  end

  assign err = err_r;
`else
  assign bad_bits = '0;
  assign err      = 1'b0;
`endif

  // Datapath: operand capture, precharge countdown, result register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      op_t  <= '0;
      op_f  <= '0;
      y_t_r <= '0;
      y_f_r <= '0;
    end else begin
      if (accept) begin
        op_t <= in_t;
        op_f <= in_f;
        cnt  <= CNT_LOAD;
      end
      if (state == PRE) begin
        if (cnt == '0) begin
          // Evaluate: bad bit positions stay at the precharge value.
          y_t_r <= and_t & ~bad_bits;
          y_f_r <= or_f  & ~bad_bits;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
      // Return to precharge on the same edge the result is consumed.
      if ((state == EVAL) && out_ready) begin
        y_t_r <= '0;
        y_f_r <= '0;
      end
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == EVAL);
  assign phase_eval = (state == EVAL);
  assign y_t        = y_t_r;
  assign y_f        = y_f_r;

endmodule
